// File: rtl/pin_lock_ctrl.sv
// pin_lock_ctrl: PIN-entry lock controller with timed grant,
// failure counting, alarmed lockout and field PIN reprogramming.
//
// Ports:
//   clk       in   rising-edge system clock
//   rstn      in   asynchronous active-low reset
//   enter     in   single-cycle attempt strobe (inpin sampled when high)
//   inpin     in   submitted PIN [PIN_W]
//   prog_req  in   level; with a matching enter requests a PIN change
//   alarm_clr in   single-cycle supervisor clear
//   access    out  grant, high for ACCESS_CYCLES cycles
//   alarm     out  latched alarm
//   locked    out  high while in LOCKOUT
//   prog_mode out  high while in PROG
//   fail      out  one-cycle pulse per wrong attempt
//   count     out  consecutive-failure count [CNT_W]
//
// Build option: define LOCK_AUTO_UNLOCK_EN to leave LOCKOUT on its own
// after LOCKOUT_CYCLES cycles; otherwise only alarm_clr or reset exit it.
module pin_lock_ctrl #(
    parameter int unsigned       PIN_W          = 16,
    parameter int unsigned       MAX_TRIES      = 3,
    parameter int unsigned       ACCESS_CYCLES  = 8,
    parameter int unsigned       LOCKOUT_CYCLES = 1024,
    parameter logic [PIN_W-1:0]  RESET_PIN      = {PIN_W{1'b0}},
    localparam int unsigned      CNT_W_RAW      = $clog2(MAX_TRIES + 1),
    localparam int unsigned      CNT_W          = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enter,
    input  logic [PIN_W-1:0] inpin,
    input  logic             prog_req,
    input  logic             alarm_clr,
    output logic             access,
    output logic             alarm,
    output logic             locked,
    output logic             prog_mode,
    output logic             fail,
    output logic [CNT_W-1:0] count
);

    // One shared down-counter serves both the grant and lockout windows.
    localparam int unsigned TMR_MAX =
        (ACCESS_CYCLES > LOCKOUT_CYCLES) ? ACCESS_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W_RAW = $clog2(TMR_MAX + 1);
    localparam int unsigned TMR_W     = (TMR_W_RAW < 1) ? 1 : TMR_W_RAW;

    // Timer is loaded with N-1 on entry and the state is left when it
    // reads zero, giving exactly N cycles in the state.
    localparam logic [TMR_W-1:0] ACC_LD  = TMR_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_PROG  = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [PIN_W-1:0] pin_q,    pin_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [TMR_W-1:0] tmr_q,    tmr_d;
    logic             access_q, access_d;
    logic             alarm_q,  alarm_d;
    logic             locked_q, locked_d;
    logic             prog_q,   prog_d;
    logic             fail_q,   fail_d;

    logic             match;
    logic [CNT_W-1:0] count_inc;

    assign match     = (inpin == pin_q);
    assign count_inc = count_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        pin_d    = pin_q;
        count_d  = count_q;
        tmr_d    = tmr_q;
        access_d = access_q;
        alarm_d  = alarm_q;
        locked_d = locked_q;
        prog_d   = prog_q;
        fail_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (alarm_clr) alarm_d = 1'b0;
                if (enter) begin
                    if (match) begin
                        count_d = '0;
                        if (prog_req) begin
                            state_d = S_PROG;
                            prog_d  = 1'b1;
                        end else begin
                            state_d  = S_GRANT;
                            access_d = 1'b1;
                            tmr_d    = ACC_LD;
                        end
                    end else begin
                        fail_d  = 1'b1;
                        count_d = count_inc;
                        // Lockout overrides a same-cycle alarm_clr.
                        if (count_inc == CNT_MAX) begin
                            state_d  = S_LOCK;
                            locked_d = 1'b1;
                            alarm_d  = 1'b1;
`ifdef LOCK_AUTO_UNLOCK_EN
                            tmr_d    = TMR_W'(LOCKOUT_CYCLES - 1);
`endif
                        end
                    end
                end
            end
            S_GRANT: begin
                if (alarm_clr) alarm_d = 1'b0;
                if (tmr_q == '0) begin
                    state_d  = S_IDLE;
                    access_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_PROG: begin
                if (alarm_clr) alarm_d = 1'b0;
                if (!prog_req) begin
                    state_d = S_IDLE;
                    prog_d  = 1'b0;
                end else if (enter) begin
                    pin_d   = inpin;
                    state_d = S_IDLE;
                    prog_d  = 1'b0;
                end
            end
            S_LOCK: begin
                // Enter is dropped here; a clear always wins.
                if (alarm_clr) begin
                    state_d  = S_IDLE;
                    count_d  = '0;
                    locked_d = 1'b0;
                    alarm_d  = 1'b0;
                    tmr_d    = '0;
                end
`ifdef LOCK_AUTO_UNLOCK_EN
                else if (tmr_q == '0) begin
                    // Alarm stays latched until a supervisor clear.
                    state_d  = S_IDLE;
                    count_d  = '0;
                    locked_d = 1'b0;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            pin_q    <= RESET_PIN;
            count_q  <= '0;
            tmr_q    <= '0;
            access_q <= 1'b0;
            alarm_q  <= 1'b0;
            locked_q <= 1'b0;
            prog_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pin_q    <= pin_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            access_q <= access_d;
            alarm_q  <= alarm_d;
            locked_q <= locked_d;
            prog_q   <= prog_d;
            fail_q   <= fail_d;
        end
    end

    assign access    = access_q;
    assign alarm     = alarm_q;
    assign locked    = locked_q;
    assign prog_mode = prog_q;
    assign fail      = fail_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// tb_pin_lock_ctrl: directed self-checking bench for pin_lock_ctrl.
// Lockout window shortened to 16 cycles.
module tb_pin_lock_ctrl;

    localparam int ACC = 8;
    localparam int LCK = 16;

    logic        clk;
    logic        rstn;
    logic        enter;
    logic [15:0] inpin;
    logic        prog_req;
    logic        alarm_clr;
    logic        access;
    logic        alarm;
    logic        locked;
    logic        prog_mode;
    logic        fail;
    logic [1:0]  count;

    int total;
    int bad;

    pin_lock_ctrl #(
        .PIN_W(16),
        .MAX_TRIES(3),
        .ACCESS_CYCLES(ACC),
        .LOCKOUT_CYCLES(LCK),
        .RESET_PIN(16'h0000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enter(enter),
        .inpin(inpin),
        .prog_req(prog_req),
        .alarm_clr(alarm_clr),
        .access(access),
        .alarm(alarm),
        .locked(locked),
        .prog_mode(prog_mode),
        .fail(fail),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic a, input logic al,
                        input logic lk, input logic pm, input logic f,
                        input logic [1:0] c);
        chk({tag, ".access"}, 32'(access), 32'(a));
        chk({tag, ".alarm"}, 32'(alarm), 32'(al));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".prog"}, 32'(prog_mode), 32'(pm));
        chk({tag, ".fail"}, 32'(fail), 32'(f));
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rstn      = 1'b0;
        enter     = 1'b0;
        inpin     = 16'h0000;
        prog_req  = 1'b0;
        alarm_clr = 1'b0;

        repeat (2) tick();
        outs("rst", 0, 0, 0, 0, 0, 2'd0);
        rstn = 1'b1;
        tick();

        // Grant with reset PIN, exactly ACC cycles of access.
        enter = 1; inpin = 16'h0000;
        tick();
        enter = 0;
        outs("grant0", 1, 0, 0, 0, 0, 2'd0);
        for (int k = 1; k < ACC; k++) begin
            tick();
            chk("grant_hold", 32'(access), 32'd1);
        end
        tick();
        outs("grant_end", 0, 0, 0, 0, 0, 2'd0);

        // Three wrong attempts back-to-back -> lockout.
        for (int i = 1; i <= 3; i++) begin
            enter = 1; inpin = 16'h1234;
            tick();
            chk("bad_fail", 32'(fail), 32'd1);
            chk("bad_count", 32'(count), 32'(i));
        end
        outs("lock", 0, 1, 1, 0, 1, 2'd3);
        enter = 1; inpin = 16'h0000;
        tick();
        enter = 0;
        outs("lock_ignore", 0, 1, 1, 0, 0, 2'd3);

        // Clear together with enter: clear wins, enter dropped.
        alarm_clr = 1; enter = 1; inpin = 16'h0000;
        tick();
        alarm_clr = 0; enter = 0;
        outs("clr", 0, 0, 0, 0, 0, 2'd0);
        enter = 1;
        tick();
        outs("clr_grant", 1, 0, 0, 0, 0, 2'd0);
        // Enter inside grant window is ignored.
        inpin = 16'h1234;
        tick();
        enter = 0;
        outs("grant_ign", 1, 0, 0, 0, 0, 2'd0);
        repeat (ACC - 1) tick();
        chk("grant2_end", 32'(access), 32'd0);

        // Program a new PIN.
        prog_req = 1; enter = 1; inpin = 16'h0000;
        tick();
        outs("prog_in", 0, 0, 0, 1, 0, 2'd0);
        inpin = 16'hBEEF;
        tick();
        prog_req = 0;
        outs("prog_cmt", 0, 0, 0, 0, 0, 2'd0);
        inpin = 16'h0000;
        tick();
        outs("old_pin", 0, 0, 0, 0, 1, 2'd1);
        inpin = 16'hBEEF;
        tick();
        enter = 0;
        outs("new_pin", 1, 0, 0, 0, 0, 2'd0);
        tick();

        // Async reset mid-grant; PIN reverts.
        #3 rstn = 1'b0;
        #1 outs("rst_mid", 0, 0, 0, 0, 0, 2'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Abort programming; reset PIN still valid.
        prog_req = 1; enter = 1; inpin = 16'h0000;
        tick();
        enter = 0;
        chk("abort_in", 32'(prog_mode), 32'd1);
        prog_req = 0;
        tick();
        outs("abort", 0, 0, 0, 0, 0, 2'd0);
        enter = 1;
        tick();
        enter = 0;
        outs("abort_pin", 1, 0, 0, 0, 0, 2'd0);
        repeat (ACC) tick();
        chk("abort_end", 32'(access), 32'd0);

        // Lockout without clear.
        for (int i = 1; i <= 3; i++) begin
            enter = 1; inpin = 16'hAAAA;
            tick();
        end
        enter = 0;
        chk("lk2", 32'(locked), 32'd1);
        repeat (LCK - 1) tick();
        chk("lk2_hold", 32'(locked), 32'd1);
        tick();
`ifdef LOCK_AUTO_UNLOCK_EN
        outs("auto_unl", 0, 1, 0, 0, 0, 2'd0);
`else
        outs("no_unl", 0, 1, 1, 0, 0, 2'd3);
        repeat (20) tick();
        chk("no_unl_late", 32'(locked), 32'd1);
`endif
        alarm_clr = 1;
        tick();
        alarm_clr = 0;
        outs("clr2", 0, 0, 0, 0, 0, 2'd0);

        // Clear coinciding with the lockout-triggering failure.
        enter = 1; inpin = 16'h5555;
        repeat (2) tick();
        alarm_clr = 1;
        tick();
        alarm_clr = 0; enter = 0;
        outs("clr_vs_lock", 0, 1, 1, 0, 1, 2'd3);
        alarm_clr = 1;
        tick();
        alarm_clr = 0;
        outs("final", 0, 0, 0, 0, 0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
